// File: rtl/regfile_mp.sv
// Two-read, one-write register file with a bulk-clear sequencer (IDLE/CLEAR/DONE).
// Define REGFILE_MP_BYPASS_EN to forward write data to matching read ports in the same cycle.
//
// state | meaning
// IDLE  | normal operation, writes accepted
// CLEAR | one register zeroed per cycle at ptr_q, writes dropped
// DONE  | single-cycle completion pulse, writes accepted
module regfile_mp #(
  parameter  int DATA_W = 16,
  parameter  int NREGS  = 8,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] writenum,
  input  logic              write,
  input  logic [ADDR_W-1:0] readnum_a,
  input  logic [ADDR_W-1:0] readnum_b,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NREGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        busy = 1'b1;
        // Exit is decoded explicitly at the last index rather than on pointer wrap.
        if (ptr_q == PTR_LAST) begin
          state_d = ST_DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (busy) begin
      regs_q[ptr_q] <= '0;
    end else if (write) begin
      regs_q[writenum] <= data_in;
    end
  end

`ifdef REGFILE_MP_BYPASS_EN
  logic wr_fwd;
  assign wr_fwd     = write && !busy;
  assign data_out_a = (wr_fwd && (readnum_a == writenum)) ? data_in : regs_q[readnum_a];
  assign data_out_b = (wr_fwd && (readnum_b == writenum)) ? data_in : regs_q[readnum_b];
`else
  assign data_out_a = regs_q[readnum_a];
  assign data_out_b = regs_q[readnum_b];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver pushes expected outputs from a
// behavioural model, a monitor pops and compares them every cycle.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;
  logic        clear;
  logic [15:0] data_out_a;
  logic [15:0] data_out_b;
  logic        busy;
  logic        done;

  regfile_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .writenum   (writenum),
    .write      (write),
    .readnum_a  (readnum_a),
    .readnum_b  (readnum_b),
    .clear      (clear),
    .data_out_a (data_out_a),
    .data_out_b (data_out_b),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: register contents plus how many clear cycles have elapsed.
  // clear_cycles < 0: no clear running; 0..7: clearing register clear_cycles; 8: completion cycle.
  logic [15:0] m_regs [8];
  int          clear_cycles = -1;
  logic        last_busy;
  logic        last_done;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: outputs are sampled mid-low-phase, after the driver has settled inputs.
  always @(negedge clk) begin
    exp_t e;
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("data_out_a", data_out_a, e.a);
      check("data_out_b", data_out_b, e.b);
      check("busy", {15'd0, busy}, {15'd0, e.busy});
      check("done", {15'd0, done}, {15'd0, e.done});
    end
  end

  function automatic logic [15:0] model_read(input logic [2:0] ra, input logic m_busy);
    logic [15:0] v;
    v = m_regs[ra];
`ifdef REGFILE_MP_BYPASS_EN
    if (write && !m_busy && ra == writenum) v = data_in;
`endif
    return v;
  endfunction

  task automatic cycle(input logic rn, input logic wr, input logic cl,
                       input logic [2:0] wn, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [15:0] din);
    exp_t e;
    logic m_busy;
    @(negedge clk);
    rst_n = rn; write = wr; clear = cl; writenum = wn;
    readnum_a = ra; readnum_b = rb; data_in = din;
    #1;
    m_busy = (clear_cycles >= 0) && (clear_cycles < 8);
    e.a    = model_read(ra, m_busy);
    e.b    = model_read(rb, m_busy);
    e.busy = m_busy;
    e.done = (clear_cycles == 8);
    exp_q.push_back(e);
    last_busy = busy;
    last_done = done;
    @(posedge clk);
    if (!rn) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0;
      clear_cycles = -1;
    end else if (m_busy) begin
      m_regs[clear_cycles] = 16'h0;
      clear_cycles++;
    end else begin
      if (wr) m_regs[wn] = din;
      clear_cycles = cl ? 0 : -1;
    end
  endtask

  task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, ra, rb, 16'($urandom));
  endtask

  task automatic fill();
    for (int k = 0; k < 8; k++)
      cycle(1'b1, 1'b1, 1'b0, 3'(k), 3'(k), 3'(7 - k), 16'($urandom) | 16'h0100);
  endtask

  task automatic sweep();
    for (int k = 0; k < 8; k++) idle(3'(k), 3'(7 - k));
  endtask

  initial begin
    int busy_run;
    int done_seen;
    rst_n = 1'b0; write = 1'b0; clear = 1'b0; writenum = '0;
    readnum_a = '0; readnum_b = '0; data_in = '0;
    foreach (m_regs[i]) m_regs[i] = 16'h0;

    // Reset overrides simultaneous write and clear.
    cycle(1'b0, 1'b1, 1'b1, 3'd2, 3'd2, 3'd0, 16'hFFFF);
    cycle(1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 3'd1, 16'hA5A5);
    sweep();

    for (int k = 0; k < 8; k++)
      cycle(1'b1, 1'b1, 1'b0, 3'(k), 3'(k), 3'(k), 16'h1110 + 16'(k));
    sweep();

    cycle(1'b1, 1'b1, 1'b0, 3'd3, 3'd3, 3'd3, 16'hABCD);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b0, 3'd3, 3'(k), 3'd3, 16'h5555);

    // Full clear: busy run length measured directly from the DUT.
    fill();
    cycle(1'b1, 1'b0, 1'b1, 3'd0, 3'd2, 3'd5, 16'h0);
    busy_run = 0; done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      idle(3'd2, 3'd5);
      if (last_busy) busy_run++;
      if (last_done) done_seen++;
    end
    check("busy_run_len", 16'(busy_run), 16'd8);
    check("done_pulses", 16'(done_seen), 16'd1);
    sweep();

    // Writes and re-clear during CLEAR are dropped.
    fill();
    cycle(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd7, 16'h0);
    idle(3'd0, 3'd7);
    idle(3'd0, 3'd7);
    cycle(1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 16'hBEEF);
    busy_run = 3;
    for (int k = 0; k < 12; k++) begin
      idle(3'd0, 3'd7);
      if (last_busy) busy_run++;
    end
    check("reclear_run_len", 16'(busy_run), 16'd8);
    sweep();

    // Reset at CLEAR cycle 4 aborts without done.
    fill();
    cycle(1'b1, 1'b0, 1'b1, 3'd0, 3'd1, 3'd6, 16'h0);
    for (int k = 0; k < 4; k++) idle(3'd1, 3'd6);
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd6, 16'h0);
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      idle(3'(k % 8), 3'd6);
      if (last_done) done_seen++;
    end
    check("abort_done_pulses", 16'(done_seen), 16'd0);

    // Forwarding check against stored R6 = 1.
    cycle(1'b1, 1'b1, 1'b0, 3'd6, 3'd6, 3'd6, 16'h0001);
    cycle(1'b1, 1'b1, 1'b0, 3'd6, 3'd6, 3'd0, 16'h7E7E);
    idle(3'd6, 3'd6);

    // Simultaneous write + clear in IDLE, then clear requested during DONE.
    fill();
    cycle(1'b1, 1'b1, 1'b1, 3'd4, 3'd4, 3'd0, 16'h4444);
    for (int k = 0; k < 8; k++) idle(3'd4, 3'(k));
    cycle(1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 3'd2, 16'h1234);
    for (int k = 0; k < 10; k++) idle(3'd1, 3'(k % 8));

    // Randomized traffic.
    for (int n = 0; n < 400; n++)
      cycle(($urandom_range(0, 60) != 0), 1'($urandom), ($urandom_range(0, 25) == 0),
            3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));

    @(negedge clk);
    #3;
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
